// File: rtl/trace_flush_controller.sv
// trace_flush_controller: captures trace words into a ping-pong buffer and hands each sealed bank to the burst write engine.
// Latency: buffer write lands in the accept cycle; the start request rises no earlier than 2 cycles after a seal.
// Backpressure: trace_ready drops only while both banks await flushing; the engine side uses start and done valid/ready handshakes.
module trace_flush_controller #(
    parameter int DataWidth       = 32,
    parameter int BufferAddrWidth = 10,
    parameter int AXIAddrWidth    = 64,
    parameter int AXIDataWidth    = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [DataWidth-1:0]       trace_data,
    input  logic                       trace_valid,
    output logic                       trace_ready,
    input  logic                       flush,
    input  logic [AXIAddrWidth-1:0]    base_addr,
    input  logic [31:0]                region_words,
    output logic [BufferAddrWidth-1:0] buf_addr,
    output logic [DataWidth-1:0]       buf_data,
    output logic                       buf_ce,
    output logic                       buf_we,
    output logic                       start_valid,
    input  logic                       start_ready,
    output logic [BufferAddrWidth-1:0] data_ptr,
    output logic [BufferAddrWidth-1:0] data_size,
    output logic [AXIAddrWidth-1:0]    axi_offset,
    input  logic                       done_valid,
    output logic                       done_ready,
    output logic [31:0]                words_flushed,
    output logic                       wrapped,
    output logic                       busy
);

    localparam int BankDepth = 1 << (BufferAddrWidth - 1);
    localparam int ByteShift = $clog2(AXIDataWidth / 8);
    localparam logic [BufferAddrWidth-1:0] BankDepthW = BufferAddrWidth'(BankDepth);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t                     state;

    // Capture side state
    logic                       wr_bank;
    logic [BufferAddrWidth-1:0] wr_count;
    logic [1:0]                 bank_full;
    logic [BufferAddrWidth-1:0] bank_len [2];

    // Flush side state
    logic                       rd_bank;
    logic [31:0]                offset_words;

    logic                       accept;
    logic                       seal;
    logic                       clear;
    logic [BufferAddrWidth-1:0] eff_count;

    logic [32:0]                end_words;
    logic                       need_wrap;
    logic [31:0]                issue_offset;
    logic [AXIAddrWidth-1:0]    issue_axi;

    // Capture is accepted whenever the bank being written is not waiting for a flush.
    assign trace_ready = !bank_full[wr_bank];
    assign accept      = trace_valid && trace_ready;

    // Buffer write port: the accepted word goes straight to the RAM this cycle.
    assign buf_ce   = accept;
    assign buf_we   = accept;
    assign buf_addr = {wr_bank, wr_count[BufferAddrWidth-2:0]};
    assign buf_data = trace_data;

    // Count including the word accepted this cycle; a flush and a fill in the
    // same cycle collapse into one seal because both use this single value.
    assign eff_count = wr_count + BufferAddrWidth'(accept);
    assign seal      = (eff_count == BankDepthW) || (flush && (eff_count != '0));

    // Completion frees the bank being flushed; it is never the bank being sealed,
    // since a full bank cannot be written and hence cannot be sealed.
    assign clear = (state == WAIT) && done_valid;

    // Wrap decision for the next request; the compare is one bit wider so a
    // large offset cannot alias past the region end.
    assign end_words    = {1'b0, offset_words} + 33'(bank_len[rd_bank]);
    assign need_wrap    = end_words > {1'b0, region_words};
    assign issue_offset = need_wrap ? 32'd0 : offset_words;
    assign issue_axi    = base_addr + (AXIAddrWidth'(issue_offset) << ByteShift);

    assign busy = (|bank_full) || (state != IDLE);

    // Capture bookkeeping: advance the write count, seal banks, and free banks on completion.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_bank     <= 1'b0;
            wr_count    <= '0;
            bank_full   <= 2'b00;
            bank_len[0] <= '0;
            bank_len[1] <= '0;
        end else begin
            if (seal) begin
                bank_full[wr_bank] <= 1'b1;
                bank_len[wr_bank]  <= eff_count;
                wr_bank            <= ~wr_bank;
                wr_count           <= '0;
            end else if (accept) begin
                wr_count <= eff_count;
            end
            if (clear) begin
                bank_full[rd_bank] <= 1'b0;
            end
        end
    end

    // Flush FSM: issue sealed banks to the engine in seal order and track the DRAM offset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            rd_bank       <= 1'b0;
            offset_words  <= '0;
            words_flushed <= '0;
            wrapped       <= 1'b0;
            start_valid   <= 1'b0;
            done_ready    <= 1'b0;
            data_ptr      <= '0;
            data_size     <= '0;
            axi_offset    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bank_full[rd_bank]) begin
                        state        <= ISSUE;
                        start_valid  <= 1'b1;
                        data_ptr     <= {rd_bank, {(BufferAddrWidth-1){1'b0}}};
                        data_size    <= bank_len[rd_bank];
                        axi_offset   <= issue_axi;
                        offset_words <= issue_offset;
                        if (need_wrap) begin
                            wrapped <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (start_ready) begin
                        state       <= WAIT;
                        start_valid <= 1'b0;
                        done_ready  <= 1'b1;
                    end
                end
                WAIT: begin
                    if (done_valid) begin
                        state         <= IDLE;
                        done_ready    <= 1'b0;
                        offset_words  <= offset_words + 32'(bank_len[rd_bank]);
                        words_flushed <= words_flushed + 32'(bank_len[rd_bank]);
                        rd_bank       <= ~rd_bank;
                    end
                end
                default: begin
                    state       <= IDLE;
                    start_valid <= 1'b0;
                    done_ready  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trace_flush_controller.sv
// Bench for trace_flush_controller with 8-word banks: vector table, hand-written
// corner sequences, and randomized traffic against a chunk-level reference model.
module tb_trace_flush_controller;

    localparam int DW  = 32;
    localparam int BAW = 4;
    localparam int AW  = 64;
    localparam int BD  = 8;

    logic           clk = 1'b0;
    logic           reset;
    logic [DW-1:0]  trace_data;
    logic           trace_valid;
    logic           trace_ready;
    logic           flush;
    logic [AW-1:0]  base_addr;
    logic [31:0]    region_words;
    logic [BAW-1:0] buf_addr;
    logic [DW-1:0]  buf_data;
    logic           buf_ce;
    logic           buf_we;
    logic           start_valid;
    logic           start_ready;
    logic [BAW-1:0] data_ptr;
    logic [BAW-1:0] data_size;
    logic [AW-1:0]  axi_offset;
    logic           done_valid;
    logic           done_ready;
    logic [31:0]    words_flushed;
    logic           wrapped;
    logic           busy;

    always #5 clk = ~clk;

    trace_flush_controller #(
        .DataWidth(DW), .BufferAddrWidth(BAW), .AXIAddrWidth(AW), .AXIDataWidth(32)
    ) dut (
        .clk(clk), .reset(reset),
        .trace_data(trace_data), .trace_valid(trace_valid), .trace_ready(trace_ready),
        .flush(flush), .base_addr(base_addr), .region_words(region_words),
        .buf_addr(buf_addr), .buf_data(buf_data), .buf_ce(buf_ce), .buf_we(buf_we),
        .start_valid(start_valid), .start_ready(start_ready),
        .data_ptr(data_ptr), .data_size(data_size), .axi_offset(axi_offset),
        .done_valid(done_valid), .done_ready(done_ready),
        .words_flushed(words_flushed), .wrapped(wrapped), .busy(busy)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: buffer RAM, accepted words, and the list of sealed chunk lengths.
    logic [DW-1:0] mem [2*BD];
    logic [DW-1:0] exp_words [$];
    int            chunk_len [$];
    int            cnt, sealed, freed, req_cnt, fl_ptr, run_off, cur_len, cur_off, m_flushed;
    bit            mwrap;
    // Engine stub
    int            eng_phase, stall_ctr, done_ctr, stall_cfg, dlat_cfg;

    typedef struct {
        logic           v;
        logic           f;
        logic [DW-1:0]  d;
        logic           rdy;
        logic           ce;
        logic [BAW-1:0] addr;
        logic           sv;
        logic           bsy;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        exp_words.delete();
        chunk_len.delete();
        cnt = 0; sealed = 0; freed = 0; req_cnt = 0; fl_ptr = 0;
        run_off = 0; cur_len = 0; cur_off = 0; m_flushed = 0; mwrap = 0;
        eng_phase = 0; stall_ctr = 0; done_ctr = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1; trace_valid = 1'b0; flush = 1'b0; trace_data = '0;
        start_ready = 1'b0; done_valid = 1'b0;
        tick(); tick();
        reset = 1'b0;
        model_reset();
    endtask

    // One clock cycle of model-checked traffic; trace inputs are set by the caller.
    task automatic cycle(output bit acc);
        bit exp_rdy;
        int nmis;
        start_ready = 1'b0;
        done_valid  = 1'b0;
        if (eng_phase == 0 && start_valid) begin
            if (stall_ctr >= stall_cfg) start_ready = 1'b1;
            else stall_ctr++;
        end
        if (eng_phase == 1) begin
            if (done_ctr >= dlat_cfg) done_valid = 1'b1;
            else done_ctr++;
        end
        #1;
        exp_rdy = (sealed - freed) < 2;
        acc     = trace_valid && exp_rdy;
        chk("trace_ready", trace_ready, exp_rdy);
        chk("buf_ce", buf_ce, acc);
        chk("buf_we", buf_we, acc);
        chk("busy", busy, (sealed - freed) > 0);
        chk("words_flushed", words_flushed, 32'(m_flushed));
        chk("done_ready", done_ready, eng_phase == 1);
        chk("spurious_start", start_valid && (req_cnt >= sealed || eng_phase == 1), 1'b0);
        if (acc) begin
            chk("buf_addr", buf_addr, (sealed % 2) * BD + cnt);
            chk("buf_data", buf_data, trace_data);
        end
        if (buf_ce && buf_we) mem[buf_addr] = buf_data;
        if (acc) begin
            exp_words.push_back(trace_data);
            cnt++;
        end
        if (cnt == BD || (flush && cnt > 0)) begin
            chunk_len.push_back(cnt);
            sealed++;
            cnt = 0;
        end
        if (start_valid && start_ready && req_cnt < chunk_len.size()) begin
            cur_len = chunk_len[req_cnt];
            cur_off = run_off;
            if (run_off + cur_len > int'(region_words)) begin
                cur_off = 0;
                mwrap   = 1'b1;
            end
            chk("data_ptr", data_ptr, (req_cnt % 2) * BD);
            chk("data_size", data_size, cur_len);
            chk("axi_offset", axi_offset, base_addr + 64'(cur_off) * 64'd4);
            chk("wrapped", wrapped, mwrap);
            nmis = 0;
            for (int k = 0; k < cur_len; k++) begin
                if (fl_ptr + k >= exp_words.size() || mem[(req_cnt % 2) * BD + k] !== exp_words[fl_ptr + k])
                    nmis++;
            end
            chk("burst_word_mismatches", nmis, 0);
            fl_ptr   += cur_len;
            req_cnt++;
            eng_phase = 1;
            done_ctr  = 0;
            stall_ctr = 0;
        end
        if (done_valid && done_ready) begin
            freed++;
            m_flushed += cur_len;
            run_off    = cur_off + cur_len;
            eng_phase  = 0;
        end
        @(posedge clk);
        #1;
    endtask

    // Stream nw words with random gaps and flushes, then drain everything.
    task automatic run(input string tag, input int nw, input int vprob, input int fprob,
                       input int stall, input int dlat, input bit cflush, input int region,
                       output int low_cycles);
        int            sent;
        int            cyc;
        bit            acc;
        logic [DW-1:0] word;
        sent = 0; cyc = 0; low_cycles = 0;
        region_words = region;
        base_addr    = {$urandom, $urandom} & ~64'h3;
        do_reset();
        stall_cfg = stall;
        dlat_cfg  = dlat;
        word = $urandom;
        while (!(sent == nw && cnt == 0 && sealed == freed && eng_phase == 0)) begin
            if (cyc >= 3000) begin
                total++; bad++;
                $display("FAIL %s timeout: sent=%0d sealed=%0d freed=%0d required all drained", tag, sent, sealed, freed);
                break;
            end
            trace_valid = (sent < nw) && (int'($urandom_range(99)) < vprob);
            trace_data  = word;
            flush = (int'($urandom_range(99)) < fprob) || (sent == nw && cnt > 0) ||
                    (cflush && trace_valid && sent == nw - 1);
            cycle(acc);
            if (trace_valid && !acc) low_cycles++;
            if (acc) begin
                sent++;
                word = $urandom;
            end
            cyc++;
        end
        trace_valid = 1'b0;
        flush = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int low;
        bit acc;

        // v, f, d, ready, ce, addr, start_valid, busy -- engine never accepts
        tbl[0] = '{1'b1, 1'b0, 32'h11, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 32'h22, 1'b1, 1'b1, 4'd1, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 32'h00, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 1'b0, 32'h33, 1'b1, 1'b1, 4'd8, 1'b0, 1'b1};
        tbl[4] = '{1'b1, 1'b0, 32'h44, 1'b1, 1'b1, 4'd9, 1'b1, 1'b1};
        tbl[5] = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b0, 4'd0, 1'b1, 1'b1};
        tbl[6] = '{1'b0, 1'b1, 32'h00, 1'b1, 1'b0, 4'd0, 1'b1, 1'b1};
        tbl[7] = '{1'b1, 1'b0, 32'h55, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1};
        tbl[8] = '{1'b1, 1'b1, 32'h55, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1};
        tbl[9] = '{1'b0, 1'b0, 32'h00, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1};

        base_addr    = 64'h0000_0010_0000_1000;
        region_words = 32'd64;
        stall_cfg = 0; dlat_cfg = 0;
        do_reset();

        // Reset state
        chk("rst_trace_ready", trace_ready, 1'b1);
        chk("rst_start_valid", start_valid, 1'b0);
        chk("rst_done_ready", done_ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_axi_offset", axi_offset, 64'd0);

        // Vector table
        for (int i = 0; i < 10; i++) begin
            trace_valid = tbl[i].v;
            flush       = tbl[i].f;
            trace_data  = tbl[i].d;
            #1;
            chk($sformatf("tbl%0d_ready", i), trace_ready, tbl[i].rdy);
            chk($sformatf("tbl%0d_ce", i), buf_ce, tbl[i].ce);
            chk($sformatf("tbl%0d_start_valid", i), start_valid, tbl[i].sv);
            chk($sformatf("tbl%0d_busy", i), busy, tbl[i].bsy);
            if (tbl[i].ce) begin
                chk($sformatf("tbl%0d_addr", i), buf_addr, tbl[i].addr);
                chk($sformatf("tbl%0d_data", i), buf_data, tbl[i].d);
            end
            @(posedge clk);
            #1;
        end
        trace_valid = 1'b0; flush = 1'b0;
        chk("tbl_req_ptr", data_ptr, 4'd0);
        chk("tbl_req_size", data_size, 4'd2);
        chk("tbl_req_axi", axi_offset, base_addr);

        // Reset during WAIT
        start_ready = 1'b1; tick(); start_ready = 1'b0;
        chk("mid_done_ready", done_ready, 1'b1);
        chk("mid_start_valid", start_valid, 1'b0);
        reset = 1'b1; tick();
        chk("mid_rst_trace_ready", trace_ready, 1'b1);
        chk("mid_rst_start_valid", start_valid, 1'b0);
        chk("mid_rst_done_ready", done_ready, 1'b0);
        chk("mid_rst_buf_ce", buf_ce, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_wrapped", wrapped, 1'b0);
        chk("mid_rst_words_flushed", words_flushed, 32'd0);
        chk("mid_rst_data_ptr", data_ptr, 4'd0);
        chk("mid_rst_data_size", data_size, 4'd0);
        chk("mid_rst_axi", axi_offset, 64'd0);
        reset = 1'b0;

        // Single partial flush: 5 words then flush
        for (int i = 0; i < 5; i++) begin
            trace_valid = 1'b1; trace_data = 32'h100 + i; tick();
        end
        trace_valid = 1'b0; flush = 1'b1; tick(); flush = 1'b0;
        chk("pf_start_lat1", start_valid, 1'b0);
        chk("pf_busy", busy, 1'b1);
        tick();
        chk("pf_start_lat2", start_valid, 1'b1);
        chk("pf_ptr", data_ptr, 4'd0);
        chk("pf_size", data_size, 4'd5);
        chk("pf_axi", axi_offset, base_addr);
        start_ready = 1'b1; tick(); start_ready = 1'b0;
        chk("pf_done_ready", done_ready, 1'b1);
        done_valid = 1'b1; tick(); done_valid = 1'b0;
        chk("pf_words_flushed", words_flushed, 32'd5);
        chk("pf_done_ready_low", done_ready, 1'b0);
        chk("pf_busy_end", busy, 1'b0);
        chk("pf_ready_end", trace_ready, 1'b1);

        // Back-to-back fill, engine takes 3 cycles per burst
        run("b2b", 16, 100, 0, 0, 3, 1'b0, 64, low);
        chk("b2b_ready_drops", low, 0);
        chk("b2b_requests", req_cnt, 2);
        chk("b2b_flushed", words_flushed, 32'd16);

        // Backpressure: engine stalls start_ready for 50 cycles
        run("bp", 20, 100, 0, 50, 2, 1'b0, 64, low);
        chk("bp_ready_dropped", low > 0, 1'b1);
        chk("bp_flushed", words_flushed, 32'd20);

        // Flush coincident with the 8th accept, then idle cycles with no extra request
        run("coinc", 8, 100, 0, 0, 1, 1'b1, 64, low);
        trace_valid = 1'b0; flush = 1'b0;
        for (int i = 0; i < 6; i++) cycle(acc);
        chk("coinc_requests", req_cnt, 1);
        chk("coinc_flushed", words_flushed, 32'd8);

        // Region wrap: 20-word region, three full banks
        run("wrap", 24, 100, 0, 0, 3, 1'b0, 20, low);
        chk("wrap_requests", req_cnt, 3);
        chk("wrap_sticky", wrapped, 1'b1);

        // Randomized traffic
        for (int r = 0; r < 6; r++) begin
            run($sformatf("rand%0d", r), $urandom_range(70, 30), $urandom_range(100, 30),
                $urandom_range(8, 0), $urandom_range(12, 0), $urandom_range(12, 0),
                1'b0, $urandom_range(48, 8), low);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/trace_flush_controller.md
# trace_flush_controller

Capture-side front end for the AXI burst write engine. It accepts a stream of trace words and writes them into one half of a ping-pong on-chip buffer through the buffer's write port. When a half fills, or software requests a flush, it hands that half to the burst write engine through the engine's start/done handshake, and it advances the DRAM write offset within a circular region. Capture continues into the other half while a flush is in progress. The engine reads the buffer through the second RAM port.

## Interface
- DataWidth, 32, trace word width; equals the buffer and AXI data widths
- BufferAddrWidth, 10, buffer address width; each bank holds BankDepth = 2^(BufferAddrWidth-1) words
- AXIAddrWidth, 64, DRAM byte-address width
- AXIDataWidth, 32, AXI data width; word stride in bytes is AXIDataWidth/8
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- trace_data  in  DataWidth  trace word
- trace_valid  in  1  trace word is present
- trace_ready  out  1  word accepted when valid & ready
- flush  in  1  single-cycle request to seal the partially filled bank
- base_addr  in  AXIAddrWidth  DRAM byte base of the circular region; must be stable while not idle
- region_words  in  32  region size in words; must be ≥ BankDepth
- buf_addr  out  BufferAddrWidth  buffer write address
- buf_data  out  DataWidth  buffer write data
- buf_ce / buf_we  out  1 / 1  buffer enable / write enable; both high on each accepted word
- start_valid  out  1  burst request to the engine
- start_ready  in  1  engine accepts the request
- data_ptr  out  BufferAddrWidth  bank base: rd_bank*BankDepth
- data_size  out  BufferAddrWidth  words in the bank: 1..BankDepth
- axi_offset  out  AXIAddrWidth  base_addr + offset_words*(AXIDataWidth/8)
- done_valid  in  1  engine has finished the burst
- done_ready  out  1  acknowledges completion
- words_flushed  out  32  running count of words confirmed written, wraps modulo 2^32
- wrapped  out  1  sticky; set on the first region wrap
- busy  out  1  high when any bank is full or the flush FSM is not in IDLE

## Operation
- **Registers:** wr_bank, wr_count[BufferAddrWidth-1:0], bank_full[1:0], bank_len[0..1], rd_bank, offset_words[31:0].
- **Capture:**
  - trace_ready = !bank_full[wr_bank].
  - On accept, the block writes to buf_addr = {wr_bank, wr_count[BufferAddrWidth-2:0]} and wr_count increments.
  - If an accept brings the count to BankDepth, the bank is sealed.
- **Seal:** bank_full[wr_bank]←1, bank_len[wr_bank]←count including any word accepted this cycle, wr_bank toggles, wr_count←0.
- **Flush:**
  - If flush is high and the effective count (wr_count plus any word accepted this cycle) is > 0, the bank is sealed with that count.
  - If the effective count is 0, flush is ignored and is not remembered.
  - A flush that coincides with a fill-seal produces a single seal.
- **Flush FSM states:**
  - IDLE: if bank_full[rd_bank], go to ISSUE. On this transition, if offset_words + bank_len[rd_bank] > region_words, offset_words←0 and wrapped←1.
  - ISSUE: start_valid=1 and the parameter outputs are driven from registers. On start_ready, go to WAIT.
  - WAIT: done_ready=1. On done_valid: bank_full[rd_bank]←0, offset_words += bank_len, words_flushed += bank_len, rd_bank toggles, go to IDLE.
- **Bank ordering:**
  - Banks are flushed strictly in seal order: rd_bank starts at 0 and toggles exactly as wr_bank does.
  - A seal and a clear on different banks in the same cycle are both applied.
  - When both banks are full, trace_ready=0 and no data is dropped.
- **Arithmetic:** 32-bit offset and counter arithmetic; the axi_offset multiply is a constant shift.
- **Reset:** returns to IDLE with all registers at 0 and the engine request abandoned. The engine is reset by the same signal.

## Timing
- **Reset values:** trace_ready=1, start_valid=0, done_ready=0, buf_ce=buf_we=0, words_flushed=0, wrapped=0, busy=0, data_ptr=data_size=axi_offset=0.
- trace_ready and buf_* are combinational from registers and the inputs. The write lands in the cycle the word is accepted, with zero latency.
- The seal is visible on bank_full in the cycle after the accept or flush. start_valid rises one cycle later (IDLE→ISSUE), so the minimum seal-to-request latency is 2 cycles.
- start_valid holds and data_ptr, data_size and axi_offset stay stable until start_ready.
- done_ready is high throughout WAIT. The bank is freed the cycle after the done handshake, so trace_ready can reassert on the next edge.
- Sustained throughput is 1 word/cycle while the engine drains a bank faster than BankDepth cycles.

## Test plan
- **Single partial flush:** reset, stream 5 words, pulse flush. Required: start with data_ptr=0, data_size=5, axi_offset=base_addr; the block answers done; words_flushed=5.
- **Back-to-back fill:** BufferAddrWidth=4 (BankDepth=8), stream 16 words continuously with the engine stub taking 3 cycles per burst. Required: two requests, data_ptr=0 then 8, axi_offset base then base+32, no trace_ready drop.
- **Backpressure:** the engine stub stalls start_ready for 50 cycles while 20 words arrive (BankDepth=8). Required: trace_ready=0 after 16 accepts, words 17–20 held, order preserved in DRAM.
- **Coincident flush:** flush in the same cycle as the 8th accept. Required: a single seal with data_size=8, followed by no empty request.
- **Region wrap:** region_words=20, three full banks of 8. Required: the third request has axi_offset=base_addr and wrapped=1.
- **Reset mid-flush:** assert reset during WAIT. Required: all outputs return to their reset values the next cycle, and the next flush starts at data_ptr=0, axi_offset=base_addr.
